// File: rtl/adder_operand_pair_seq_if.sv
// Operand-pair bus between the network-side senders and the adder pairing stage.
// master: the side that drives operands and the enable; slave: the pairing stage.
interface adder_operand_pair_seq_if #(
  parameter int DATA_WIDTH = 16
);
  logic [1:0]              i_valid;
  logic [2*DATA_WIDTH-1:0] i_data_bus;
  logic [1:0]              o_ready;
  logic [1:0]              o_valid;
  logic [2*DATA_WIDTH-1:0] o_data_bus;
  logic                    i_en;

  modport slave (
    input  i_valid, i_data_bus, i_en,
    output o_ready, o_valid, o_data_bus
  );

  modport master (
    output i_valid, i_data_bus, i_en,
    input  o_ready, o_valid, o_data_bus
  );
endinterface

// File: rtl/adder_operand_pair_seq.sv
// Operand pairing stage in front of the sequential two-operand adder.
// Side 0 buffers operand b, side 1 buffers operand a, each in its own small
// FIFO. A pair {a,b} is issued (o_valid=2'b11 for one cycle) only when both
// FIFOs hold data and the adder enable is high, so the n-th a always meets
// the n-th b. Readiness and pop decisions use registered counts only.
// Optional build macro: ADDER_PAIR_SKEW_CNT_EN adds o_skew_cnt, a saturating
// count of cycles in which exactly one side is non-empty.
module adder_operand_pair_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic clk,
  input  logic rst,
  adder_operand_pair_seq_if.slave if_pair
`ifdef ADDER_PAIR_SKEW_CNT_EN
  ,
  output logic [15:0] o_skew_cnt
`endif
);

  localparam logic [PTR_WIDTH:0]   LP_FULL    = (PTR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0]   LP_CNT_ONE = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] LP_PTR_ONE = PTR_WIDTH'(1);

  logic [1:0][DATA_WIDTH-1:0] w_head;
  logic [1:0]                 w_ready;
  logic [1:0]                 w_nonempty;
  logic                       w_pop;

  logic                       r_valid;
  logic [2*DATA_WIDTH-1:0]    r_data;

  // Both heads leave together, so a pop needs data on both sides.
  assign w_pop = if_pair.i_en & w_nonempty[0] & w_nonempty[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_side
      logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
      logic [PTR_WIDTH-1:0]  r_wr_ptr;
      logic [PTR_WIDTH-1:0]  r_rd_ptr;
      logic [PTR_WIDTH:0]    r_count;
      logic                  w_wr;

      // Full is judged on the registered count: a same-cycle pop does not
      // open a slot for a write.
      assign w_ready[gi]    = (r_count != LP_FULL);
      assign w_nonempty[gi] = (r_count != '0);
      assign w_wr           = if_pair.i_valid[gi] & w_ready[gi];
      assign w_head[gi]     = r_mem[r_rd_ptr];

      // Operand storage; contents need no reset because the count guards reads.
      always_ff @(posedge clk) begin
        if (w_wr) begin
          r_mem[r_wr_ptr] <= if_pair.i_data_bus[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
          end
          case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + LP_CNT_ONE;
            2'b01:   r_count <= r_count - LP_CNT_ONE;
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

  // Output register: one-cycle pair strobe with the popped heads, x when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= 'x;
    end else begin
      r_valid <= w_pop;
      r_data  <= w_pop ? {w_head[1], w_head[0]} : 'x;
    end
  end

  assign if_pair.o_ready    = w_ready;
  assign if_pair.o_valid    = {2{r_valid}};
  assign if_pair.o_data_bus = r_data;

`ifdef ADDER_PAIR_SKEW_CNT_EN
  logic [15:0] r_skew_cnt;

  // Count cycles where one operand is waiting on the other; saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skew_cnt <= '0;
    end else if ((w_nonempty[0] ^ w_nonempty[1]) && (r_skew_cnt != 16'hFFFF)) begin
      r_skew_cnt <= r_skew_cnt + 16'd1;
    end
  end

  assign o_skew_cnt = r_skew_cnt;
`endif

endmodule

// File: tb/tb_adder_operand_pair_seq.sv
// Directed bench for adder_operand_pair_seq: reset, skewed arrival, full side,
// streaming, enable gating and reset mid-operation. Inputs change 1 time unit
// after posedge; outputs are sampled at that same point.
module tb_adder_operand_pair_seq;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  adder_operand_pair_seq_if #(.DATA_WIDTH(DW)) u_if ();

`ifdef ADDER_PAIR_SKEW_CNT_EN
  logic [15:0] w_skew_cnt;
`endif

  adder_operand_pair_seq #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(4),
    .PTR_WIDTH (2)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .if_pair(u_if)
`ifdef ADDER_PAIR_SKEW_CNT_EN
    ,
    .o_skew_cnt(w_skew_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 64'(u_if.o_valid), 64'h0);
  endtask

  task automatic chk_pair(input string tag, input logic [15:0] a, input logic [15:0] b);
    chk({tag, " valid"}, 64'(u_if.o_valid), 64'h3);
    chk({tag, " data"}, 64'(u_if.o_data_bus), 64'({a, b}));
  endtask

  task automatic drive(input logic [1:0] v, input logic [15:0] a, input logic [15:0] b);
    u_if.i_valid    = v;
    u_if.i_data_bus = {a, b};
  endtask

  initial begin
    rst = 1'b1;
    u_if.i_en = 1'b0;
    drive(2'b00, 16'h0, 16'h0);

    // Reset
    step();
    step();
    chk_idle("reset");
    chk("reset ready", 64'(u_if.o_ready), 64'h3);
    rst = 1'b0;
    u_if.i_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle($sformatf("post-reset idle %0d", i));
    end

    // Skewed arrival: b at cycle 0, a at cycle 3
    drive(2'b01, 16'h0, 16'h0003);
    step();
    drive(2'b00, 16'h0, 16'h0);
    chk_idle("skew c0");
    step();
    chk_idle("skew c1");
    step();
    chk_idle("skew c2");
    drive(2'b10, 16'h0005, 16'h0);
    step();
    drive(2'b00, 16'h0, 16'h0);
    chk_idle("skew c3");
    step();
    chk_pair("skew pair", 16'h0005, 16'h0003);
    step();
    chk_idle("skew single pulse");

    // Full side: b = 1..4 accepted, 5 held
    for (int k = 1; k <= 4; k++) begin
      drive(2'b01, 16'h0, 16'(k));
      step();
      chk($sformatf("full ready0 after b%0d", k), 64'(u_if.o_ready[0]), (k == 4) ? 64'h0 : 64'h1);
      chk_idle($sformatf("full idle b%0d", k));
    end
    drive(2'b01, 16'h0, 16'd5);
    step();
    chk("full b5 held ready0", 64'(u_if.o_ready[0]), 64'h0);
    drive(2'b11, 16'd10, 16'd5);
    step();
    chk_idle("full a10 written");
    drive(2'b01, 16'h0, 16'd5);
    step();
    chk_pair("full first pair", 16'd10, 16'd1);
    chk("full ready0 after pop", 64'(u_if.o_ready[0]), 64'h1);
    step();
    drive(2'b00, 16'h0, 16'h0);
    chk_idle("full b5 accepted");
    // Drain remaining b = 2..5 with a = 11..14
    for (int j = 0; j < 4; j++) begin
      drive(2'b10, 16'(11 + j), 16'h0);
      step();
      if (j == 0) chk_idle("drain start");
      else chk_pair($sformatf("drain pair %0d", j), 16'(10 + j), 16'(1 + j));
    end
    drive(2'b00, 16'h0, 16'h0);
    step();
    chk_pair("drain pair 4", 16'd14, 16'd5);
    step();
    chk_idle("drain done");

    // Streaming: a = i, b = 2i for 8 cycles
    for (int i = 1; i <= 8; i++) begin
      drive(2'b11, 16'(i), 16'(2 * i));
      step();
      chk($sformatf("stream ready %0d", i), 64'(u_if.o_ready), 64'h3);
      if (i == 1) chk_idle("stream first");
      else chk_pair($sformatf("stream pair %0d", i - 1), 16'(i - 1), 16'(2 * (i - 1)));
    end
    drive(2'b00, 16'h0, 16'h0);
    step();
    chk_pair("stream pair 8", 16'd8, 16'd16);
    step();
    chk_idle("stream done");

    // Enable gating
    u_if.i_en = 1'b0;
    drive(2'b11, 16'h0021, 16'h0031);
    step();
    chk_idle("en load 1");
    drive(2'b11, 16'h0022, 16'h0032);
    step();
    chk_idle("en load 2");
    drive(2'b00, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle($sformatf("en low %0d", i));
    end
    u_if.i_en = 1'b1;
    step();
    chk_pair("en pair 1", 16'h0021, 16'h0031);
    step();
    chk_pair("en pair 2", 16'h0022, 16'h0032);
    step();
    chk_idle("en done");

    // Reset mid-operation: three b buffered, then reset, then a = 7
    for (int k = 1; k <= 3; k++) begin
      drive(2'b01, 16'h0, 16'(k + 32));
      step();
    end
    drive(2'b00, 16'h0, 16'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("midrst reset");
    chk("midrst ready", 64'(u_if.o_ready), 64'h3);
    drive(2'b10, 16'd7, 16'h0);
    step();
    drive(2'b00, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle($sformatf("midrst no pair %0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/adder_operand_pair_seq.md
Name: adder_operand_pair_seq

Overview:
- Sits directly upstream of the sequential two-operand adder.
- Collects operand a (side 1) and operand b (side 0), which arrive independently from two network ports at different times.
- Buffers each side in a small per-side FIFO and issues a pair only when both sides hold data and the adder is enabled.
- Presents {a,b} with i_valid-style 2-bit valid and a 2*DATA_WIDTH packed bus, so the adder sees both valid bits high in the same cycle.

Parameters:
- DATA_WIDTH, 16, width of one operand.
- FIFO_DEPTH, 4, entries per side; power of two, >= 2.
- PTR_WIDTH, 2, log2(FIFO_DEPTH); must be set consistently with FIFO_DEPTH.

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  synchronous active-high reset.
- i_valid  input  2  [0] = operand b valid, [1] = operand a valid.
- i_data_bus  input  2*DATA_WIDTH  [0+:DATA_WIDTH] = b, [DATA_WIDTH+:DATA_WIDTH] = a.
- o_ready  output  2  per-side FIFO not full: [0] = b side, [1] = a side.
- o_valid  output  2  pair valid to adder; always 2'b11 or 2'b00.
- o_data_bus  output  2*DATA_WIDTH  paired operands, same packing as i_data_bus.
- i_en  input  1  downstream adder enable; pairing/issue permitted only when high.

Behaviour:
- Reset (rst=1 at posedge, regardless of i_en):
  - Pointers and counts cleared.
  - o_valid = 2'b00; o_data_bus = {2*DATA_WIDTH{1'bx}}; o_ready = 2'b11 from the next cycle.
  - Reset mid-operation discards all buffered operands and any pair being issued.
- Write, side k:
  - Occurs at posedge when i_valid[k] & o_ready[k]; data stored at tail, count_k + 1.
  - o_ready[k] = (count_k != FIFO_DEPTH), derived from registered count only; no same-cycle pass-through on full.
  - i_valid[k] while o_ready[k]=0 is dropped; the sender must hold.
- Pop:
  - pop = i_en & (count_0 != 0) & (count_1 != 0), evaluated on registered counts.
  - On pop, both heads are read and both counts decrement.
  - Next cycle: o_valid = 2'b11, o_data_bus = {head_1, head_0}.
  - No pop: next cycle o_valid = 2'b00, o_data_bus = all x.
- Simultaneous write and pop on one side: count unchanged, both pointers advance.
- Full side with a pop in the same cycle: o_ready is still 0 that cycle; no write.
- Pointers wrap modulo FIFO_DEPTH.
- Latency: the pair completes at posedge t when the last operand is written; o_valid=2'b11 after posedge t+1. Minimum 2 edges from last input valid to output.
- Throughput: one pair per cycle when both sides are streaming and i_en=1.
- i_en=0: no pops, o_valid = 2'b00 next cycle, writes still accepted until full.
- Ordering: FIFO per side; the n-th a is always paired with the n-th b.

Optional Feature:
- Macro ADDER_PAIR_SKEW_CNT_EN.
- Defined:
  - Adds output o_skew_cnt [15:0], a saturating count of cycles where exactly one side is non-empty.
  - Cleared by rst; holds at 16'hFFFF.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: rst high 2 cycles -> o_valid=00, o_ready=11, no pair issued afterward with no input.
- Skewed arrival, i_en=1:
  - Stimulus: b=16'h0003 at cycle 0, a=16'h0005 at cycle 3.
  - Required: o_valid=11 after posedge 4, o_data_bus={16'h0005,16'h0003}, exactly one pulse.
- Full side:
  - Stimulus: 5 consecutive b writes (1..5), no a.
  - Required: o_ready[0]=0 after the 4th; 5th held by the sender; after a=10 arrives, the first pair is {10,1}.
- Streaming, both sides valid every cycle for 8 cycles (a=i, b=2i):
  - Required: 8 back-to-back pairs {i,2i} in order; o_ready stays 11.
- i_en gating:
  - Stimulus: both sides hold 2 entries, i_en=0 for 3 cycles, then 1.
  - Required: o_valid=00 while low; then two pairs on consecutive cycles.
- Reset mid-operation: 3 b entries buffered, rst pulse, then a=7 -> no pair issued (b side empty).
